exu_alu_mc: RTL and testbench

Parametrised next-generation integer ALU for the EXU with a valid/ready handshake on both sides.
- Logic, add/sub, compare, branch and jump ops resolve in one cycle.
- Shifts run iteratively, SHIFT_STEP bits per cycle, to cut shifter area at wide XLEN.
- Branch resolution (taken, mispredict, flush_upper, flush_path) is produced with the result.
- Sits between decode/issue and the EXU writeback mux.

---
 rtl/exu_alu_mc_pkg.sv | 35 +++
 rtl/exu_alu_mc_if.sv | 33 +++
 rtl/exu_alu_mc_shift_iter.sv | 55 +++++
 rtl/exu_alu_mc.sv | 138 +++++++++++++
 tb/tb_exu_alu_mc.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_alu_mc_pkg.sv
// Shared types for the multi-cycle EXU ALU: op encodings, FSM states and shift modes.
// ROL/ROR are only treated as shifts when EXU_ALU_ROTATE_EN is defined.
package exu_alu_mc_pkg;

  // ROL/ROR keep their encodings in every build so decode tables stay stable.
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROL, ALU_ROR,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_JAL, ALU_JALR
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_mc_state_e;

  typedef enum logic [2:0] {SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR} shift_mode_e;

  function automatic logic is_shift_op(alu_op_e op);
`ifdef EXU_ALU_ROTATE_EN
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROL, ALU_ROR};
`else
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
`endif
  endfunction

  function automatic shift_mode_e shift_mode(alu_op_e op);
    case (op)
      ALU_SRL: return SH_SRL;
      ALU_SRA: return SH_SRA;
      ALU_ROL: return SH_ROL;
      ALU_ROR: return SH_ROR;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/exu_alu_mc_if.sv
// Issue-side and writeback-side handshake bundle of the multi-cycle ALU.
interface exu_alu_mc_if
  import exu_alu_mc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int BRIMM_W = 12
);
  logic               in_valid;
  logic               in_ready;
  alu_op_e            op;
  logic [XLEN-1:0]    a;
  logic [XLEN-1:0]    b;
  logic [XLEN-2:0]    pc;
  logic               pc4;
  logic [BRIMM_W-1:0] brimm;
  logic               predict_t;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out;
  logic               actual_taken;
  logic               flush_upper;
  logic [XLEN-2:0]    flush_path;

  modport master (
    output in_valid, op, a, b, pc, pc4, brimm, predict_t, out_ready,
    input  in_ready, out_valid, out, actual_taken, flush_upper, flush_path
  );

  modport slave (
    input  in_valid, op, a, b, pc, pc4, brimm, predict_t, out_ready,
    output in_ready, out_valid, out, actual_taken, flush_upper, flush_path
  );
endinterface

// File: rtl/exu_alu_mc_shift_iter.sv
// Iterative shifter: moves SHIFT_STEP bits per step until the loaded count is used up.
// The rotate (wrap-around fill) mux exists only when EXU_ALU_ROTATE_EN is defined.
module exu_alu_shift_iter
  import exu_alu_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4,
  localparam int SHW       = $clog2(XLEN),
  localparam int CW        = SHW + 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            start,
  input  logic            step,
  input  shift_mode_e     mode,
  input  logic [XLEN-1:0] opnd,
  input  logic [SHW-1:0]  shamt,
  output logic            last,
  output logic [XLEN-1:0] data_nxt
);
  logic [XLEN-1:0] data_q;
  logic [CW-1:0]   rem_q, amt;
  shift_mode_e     mode_q;

  assign amt  = (rem_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : rem_q;
  assign last = (rem_q <= CW'(SHIFT_STEP));

  always_comb begin
    data_nxt = data_q << amt;
    case (mode_q)
      SH_SRL: data_nxt = data_q >> amt;
      SH_SRA: data_nxt = XLEN'($signed(data_q) >>> amt);
`ifdef EXU_ALU_ROTATE_EN
      SH_ROL: data_nxt = (data_q << amt) | (data_q >> (CW'(XLEN) - amt));
      SH_ROR: data_nxt = (data_q >> amt) | (data_q << (CW'(XLEN) - amt));
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      data_q <= '0;
      rem_q  <= '0;
      mode_q <= SH_SLL;
    end else if (start) begin
      data_q <= opnd;
      rem_q  <= {1'b0, shamt};
      mode_q <= mode;
    end else if (step) begin
      data_q <= data_nxt;
      rem_q  <= rem_q - amt;
    end
  end
endmodule

// File: rtl/exu_alu_mc.sv
// Multi-cycle integer ALU: one-cycle logic/arith/branch/jump, iterative shifts.
// Define EXU_ALU_ROTATE_EN to make ROL/ROR legal (otherwise they yield 0).
module exu_alu_mc
  import exu_alu_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4,
  parameter int BRIMM_W    = 12
) (
  input logic         clk,
  input logic         rst_l,
  input logic         flush,
  exu_alu_mc_if.slave io
);
  localparam int SHW = $clog2(XLEN);

  alu_mc_state_e   state, state_nxt;
  logic            in_rdy, accept, iter, sh_last;
  logic [SHW-1:0]  shamt;
  logic [XLEN:0]   diff;
  logic            lt_s, lt_u, ov;
  logic [XLEN-1:0] res, out_q, sh_nxt;
  logic [XLEN-2:0] fp, fpath_q;
  logic            tk, mp, taken_q, mp_q, first_q;

  assign shamt = io.b[SHW-1:0];
  assign iter  = is_shift_op(io.op) && (shamt != '0);

  // Compare from a + ~b + 1: unsigned lt is the missing carry, signed lt is neg^ov.
  assign diff = {1'b0, io.a} + {1'b0, ~io.b} + (XLEN+1)'(1);
  assign ov   = (io.a[XLEN-1] ^ io.b[XLEN-1]) & (diff[XLEN-1] ^ io.a[XLEN-1]);
  assign lt_s = diff[XLEN-1] ^ ov;
  assign lt_u = ~diff[XLEN];

  always_comb begin
    res = '0;
    tk  = 1'b0;
    mp  = 1'b0;
    fp  = '0;
    case (io.op)
      ALU_ADD:  res = io.a + io.b;
      ALU_SUB:  res = diff[XLEN-1:0];
      ALU_SLT:  res = XLEN'(lt_s);
      ALU_SLTU: res = XLEN'(lt_u);
      ALU_AND:  res = io.a & io.b;
      ALU_OR:   res = io.a | io.b;
      ALU_XOR:  res = io.a ^ io.b;
      ALU_LUI:  res = io.b;
      // Shift by zero completes here; nonzero counts go to the iterator.
      ALU_SLL, ALU_SRL, ALU_SRA: res = io.a;
`ifdef EXU_ALU_ROTATE_EN
      ALU_ROL, ALU_ROR: res = io.a;
`endif
      ALU_BEQ:  tk = (diff[XLEN-1:0] == '0);
      ALU_BNE:  tk = (diff[XLEN-1:0] != '0);
      ALU_BLT:  tk = lt_s;
      ALU_BGE:  tk = ~lt_s;
      ALU_BLTU: tk = lt_u;
      ALU_BGEU: tk = ~lt_u;
      ALU_JAL, ALU_JALR: begin
        res = {io.pc, 1'b0} + (io.pc4 ? XLEN'(4) : XLEN'(2));
        tk  = 1'b1;
        mp  = 1'b1;
        fp  = (XLEN-1)'((io.a + io.b) >> 1);
      end
      default: ;
    endcase
    if (io.op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU}) begin
      mp = io.predict_t ^ tk;
      fp = tk ? io.pc + (XLEN-1)'($signed(io.brimm))
              : io.pc + (io.pc4 ? (XLEN-1)'(2) : (XLEN-1)'(1));
    end
  end

  always_comb begin
    in_rdy    = rst_l & ~flush & ((state == IDLE) | ((state == DONE) & io.out_ready));
    accept    = io.in_valid & in_rdy;
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nxt = iter ? SHIFT : DONE;
        SHIFT:   if (sh_last) state_nxt = DONE;
        DONE:    if (io.out_ready) state_nxt = accept ? (iter ? SHIFT : DONE) : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      out_q   <= '0;
      taken_q <= 1'b0;
      fpath_q <= '0;
      mp_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      if (accept && !iter) begin
        out_q   <= res;
        taken_q <= tk;
        fpath_q <= fp;
        mp_q    <= mp;
      end else if (accept) begin
        taken_q <= 1'b0;
        fpath_q <= '0;
        mp_q    <= 1'b0;
      end else if (state == SHIFT && sh_last) begin
        out_q <= sh_nxt;
      end
      // Marks the first DONE cycle of each result so flush_upper pulses once.
      first_q <= (state_nxt == DONE) & ((state != DONE) | accept);
    end
  end

  exu_alu_shift_iter #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shift (
    .clk      (clk),
    .rst_l    (rst_l),
    .start    (accept & iter),
    .step     (state == SHIFT),
    .mode     (shift_mode(io.op)),
    .opnd     (io.a),
    .shamt    (shamt),
    .last     (sh_last),
    .data_nxt (sh_nxt)
  );

  assign io.in_ready     = in_rdy;
  assign io.out_valid    = (state == DONE);
  assign io.out          = out_q;
  assign io.actual_taken = taken_q;
  assign io.flush_path   = fpath_q;
  assign io.flush_upper  = (state == DONE) & first_q & mp_q & ~flush;
endmodule

// File: tb/tb_exu_alu_mc.sv
// Directed and random checks of exu_alu_mc against a plain-arithmetic reference model.
module tb_exu_alu_mc;
  import exu_alu_mc_pkg::*;

  logic clk, rst_l, flush;
  int   ntests = 0, nfail = 0;

  exu_alu_mc_if #(.XLEN(32), .BRIMM_W(12)) io ();

  exu_alu_mc #(.XLEN(32), .SHIFT_STEP(4), .BRIMM_W(12)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .flush (flush),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout ran=%0d", ntests);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_br(alu_op_e op);
    return op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  endfunction

  function automatic logic is_jmp(alu_op_e op);
    return op inside {ALU_JAL, ALU_JALR};
  endfunction

  function automatic logic m_taken(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_BEQ:  return a == b;
      ALU_BNE:  return a != b;
      ALU_BLT:  return $signed(a) < $signed(b);
      ALU_BGE:  return $signed(a) >= $signed(b);
      ALU_BLTU: return a < b;
      ALU_BGEU: return a >= b;
      ALU_JAL, ALU_JALR: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_out(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                        logic [30:0] pc, logic pc4);
    int sh = int'(b[4:0]);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_LUI:  return b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'($signed(a) >>> sh);
`ifdef EXU_ALU_ROTATE_EN
      ALU_ROL:  return (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      ALU_ROR:  return (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
`endif
      ALU_JAL, ALU_JALR: return {pc, 1'b0} + (pc4 ? 32'd4 : 32'd2);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int m_lat(alu_op_e op, logic [31:0] b);
    int  sh = int'(b[4:0]);
    logic s;
`ifdef EXU_ALU_ROTATE_EN
    s = op inside {ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROL, ALU_ROR};
`else
    s = op inside {ALU_SLL, ALU_SRL, ALU_SRA};
`endif
    return (s && sh != 0) ? 1 + (sh + 3) / 4 : 1;
  endfunction

  function automatic logic [30:0] m_fpath(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                          logic [30:0] pc, logic pc4, logic [11:0] brimm);
    logic t = m_taken(op, a, b);
    if (is_jmp(op)) return 31'((a + b) >> 1);
    if (!is_br(op)) return '0;
    return t ? pc + 31'($signed(brimm)) : pc + (pc4 ? 31'd2 : 31'd1);
  endfunction

  task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [30:0] pc, input logic pc4, input logic [11:0] brimm,
                       input logic pt);
    io.op = op; io.a = a; io.b = b; io.pc = pc; io.pc4 = pc4;
    io.brimm = brimm; io.predict_t = pt; io.in_valid = 1'b1;
  endtask

  // Issue one op from IDLE with out_ready=1 and check latency and all result fields.
  task automatic run_op(input string tag, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [30:0] pc, input logic pc4,
                        input logic [11:0] brimm, input logic pt);
    int   cyc;
    logic t = m_taken(op, a, b);
    logic m = is_br(op) ? (pt ^ t) : is_jmp(op);
    drive(op, a, b, pc, pc4, brimm, pt);
    #1;
    chk({tag, "_in_ready"}, io.in_ready, 1);
    tick;
    io.in_valid = 1'b0;
    cyc = 1;
    while (!io.out_valid && cyc < 40) begin
      chk({tag, "_busy"}, io.in_ready, 0);
      tick;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, m_lat(op, b));
    chk({tag, "_out"}, io.out, m_out(op, a, b, pc, pc4));
    chk({tag, "_taken"}, io.actual_taken, t);
    chk({tag, "_flush_upper"}, io.flush_upper, m);
    if (is_br(op) || is_jmp(op))
      chk({tag, "_flush_path"}, io.flush_path, m_fpath(op, a, b, pc, pc4, brimm));
    tick;
    chk({tag, "_drain"}, io.out_valid, 0);
  endtask

  initial begin
    logic [31:0] o_hold;
    logic [30:0] p_hold;
    rst_l = 1'b0; flush = 1'b0;
    io.in_valid = 1'b0; io.out_ready = 1'b1; io.op = ALU_ADD;
    io.a = '0; io.b = '0; io.pc = '0; io.pc4 = 1'b1; io.brimm = '0; io.predict_t = 1'b0;
    tick; tick;
    chk("rst_in_ready", io.in_ready, 0);
    rst_l = 1'b1;
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out", io.out, 0);
    chk("rst_taken", io.actual_taken, 0);
    chk("rst_flush_upper", io.flush_upper, 0);
    chk("rst_flush_path", io.flush_path, 0);
    chk("rst_in_ready_idle", io.in_ready, 1);

    // ADD then back-to-back SUB accepted while the ADD result drains.
    drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, '0, 1'b1, '0, 1'b0);
    tick;
    drive(ALU_SUB, 32'd5, 32'd7, '0, 1'b1, '0, 1'b0);
    #1;
    chk("b2b_add_valid", io.out_valid, 1);
    chk("b2b_add_out", io.out, 32'h8000_0000);
    chk("b2b_in_ready", io.in_ready, 1);
    tick;
    io.in_valid = 1'b0;
    chk("b2b_sub_valid", io.out_valid, 1);
    chk("b2b_sub_out", io.out, 32'hFFFF_FFFE);
    tick;

    run_op("sra31", ALU_SRA, 32'h8000_0000, 32'd31, '0, 1'b1, '0, 1'b0);
    run_op("blt", ALU_BLT, 32'hFFFF_FFFF, 32'd1, 31'h100, 1'b1, 12'h010, 1'b0);
    run_op("ror1", ALU_ROR, 32'h0000_0001, 32'd1, '0, 1'b1, '0, 1'b0);
    run_op("sll0", ALU_SLL, 32'h1234_5678, 32'd0, '0, 1'b1, '0, 1'b0);
    run_op("bne_nt", ALU_BNE, 32'd9, 32'd9, 31'h40, 1'b0, 12'hFF0, 1'b0);

    // Flush three cycles into an SRL; a same-cycle ADD offer must be dropped.
    drive(ALU_SRL, 32'hF0F0_F0F0, 32'd16, '0, 1'b1, '0, 1'b0);
    tick;
    io.in_valid = 1'b0;
    tick; tick;
    drive(ALU_ADD, 32'd1, 32'd2, '0, 1'b1, '0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", io.in_ready, 0);
    chk("flush_valid_t3", io.out_valid, 0);
    tick;
    flush = 1'b0; io.in_valid = 1'b0;
    #1;
    chk("flush_in_ready_t4", io.in_ready, 1);
    chk("flush_valid_t4", io.out_valid, 0);
    chk("flush_fu_t4", io.flush_upper, 0);
    tick;
    chk("flush_valid_t5", io.out_valid, 0);

    // JAL held in DONE for three cycles by backpressure.
    io.out_ready = 1'b0;
    drive(ALU_JAL, 32'h0000_1000, 32'h0000_0024, 31'h200, 1'b1, '0, 1'b1);
    tick;
    io.in_valid = 1'b0;
    o_hold = io.out;
    p_hold = io.flush_path;
    chk("jal_out", o_hold, m_out(ALU_JAL, 32'h1000, 32'h24, 31'h200, 1'b1));
    chk("jal_path", p_hold, 31'h812);
    chk("jal_fu_first", io.flush_upper, 1);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("jal_hold_valid", io.out_valid, 1);
      chk("jal_hold_out", io.out, o_hold);
      chk("jal_hold_path", io.flush_path, p_hold);
      chk("jal_hold_fu", io.flush_upper, 0);
    end
    io.out_ready = 1'b1;
    tick;
    chk("jal_drain", io.out_valid, 0);

    // Flush coinciding with a mispredict pulse suppresses it.
    drive(ALU_BNE, 32'd3, 32'd3, 31'h80, 1'b1, 12'h004, 1'b1);
    tick;
    io.in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_fu_kill", io.flush_upper, 0);
    tick;
    flush = 1'b0;
    chk("flush_fu_valid", io.out_valid, 0);

    // Reset while shifting.
    drive(ALU_SRA, 32'h8000_0000, 32'd31, '0, 1'b1, '0, 1'b0);
    tick;
    io.in_valid = 1'b0;
    tick;
    rst_l = 1'b0;
    tick;
    chk("rst_mid_valid", io.out_valid, 0);
    chk("rst_mid_in_ready", io.in_ready, 0);
    chk("rst_mid_out", io.out, 0);
    rst_l = 1'b1;
    #1;
    chk("rst_mid_ready_after", io.in_ready, 1);

    for (int i = 0; i < 60; i++) begin
      alu_op_e     op = alu_op_e'(5'($urandom_range(0, 20)));
      logic [31:0] ra = $urandom;
      logic [31:0] rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op("rnd", op, ra, rb, 31'($urandom), 1'($urandom), 12'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
